muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the EX stage.
- Accepts a decoded MULT/MULTU/DIV/DIVU request and holds the pipeline with a stall request while it works.
- Runs a radix-2 restoring divider, one iteration per cycle, and a fixed-latency multiply counter.
- On completion it delivers HI/LO to the HI/LO register write port, using the decoder's hilo_write path.

---
 rtl/muldiv_ctrl_if.sv | 24 ++
 rtl/muldiv_ctrl.sv | 136 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> muldiv sequencer bundle: request/operands/flush in, stall/busy/HI-LO result out.
// master = EX side driving the request; slave = the sequencer.
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_o;
  logic        busy;
  logic        result_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall_o, busy, result_valid, hi_o, lo_o
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall_o, busy, result_valid, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer (radix-2 restoring divide); MULDIV_EARLY_OUT_EN adds a |a|<|b| divide shortcut.
// Latency MUL_CYCLES+1 / DIV_CYCLES+1 / 1 (div-by-zero); holds EX with combinational stall_o, result is a one-cycle pulse.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          resetn,
  muldiv_ctrl_if.slave  md
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic is_div;
    logic sign_q;
    logic sign_r;
  } ctl_t;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  ctl_t          ctl_q;
  logic [31:0]   rem_q;
  logic [31:0]   quo_q;   // dividend/quotient, or multiplicand magnitude
  logic [31:0]   dvs_q;   // divisor, or multiplier magnitude
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  logic        sgn_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        early_out;
  logic        accept;
  logic [32:0] sh_rem;
  logic        fits;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [63:0] prod;
  logic [63:0] prod_fix;

  assign sgn_op   = ~md.op[0];
  assign mag_a    = (sgn_op && md.src_a[31]) ? -md.src_a : md.src_a;
  assign mag_b    = (sgn_op && md.src_b[31]) ? -md.src_b : md.src_b;
  assign div_zero = md.op[1] && (md.src_b == 32'd0);
  assign accept   = (state == S_IDLE) && md.start && !md.flush;

`ifdef MULDIV_EARLY_OUT_EN
  // |a|==0 with a nonzero divisor is a subset of |a|<|b|: remainder=a, quotient=0.
  assign early_out = md.op[1] && !div_zero && (mag_a < mag_b);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: the shifted remainder needs 33 bits before the trial subtract.
  assign sh_rem  = {rem_q, quo_q[31]};
  assign fits    = (sh_rem >= {1'b0, dvs_q});
  assign rem_nxt = fits ? 32'(sh_rem - {1'b0, dvs_q}) : sh_rem[31:0];
  assign quo_nxt = {quo_q[30:0], fits};

  assign prod     = {32'd0, quo_q} * {32'd0, dvs_q};
  assign prod_fix = ctl_q.sign_q ? -prod : prod;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      ctl_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ctl_q <= '{is_div: md.op[1],
                       sign_q: sgn_op & (md.src_a[31] ^ md.src_b[31]),
                       sign_r: sgn_op & md.src_a[31]};
            rem_q <= '0;
            quo_q <= mag_a;
            dvs_q <= mag_b;
            if (div_zero) begin
              hi_q  <= md.src_a;
              lo_q  <= 32'hFFFF_FFFF;
              state <= S_DONE;
            end else if (early_out) begin
              hi_q  <= md.src_a;
              lo_q  <= '0;
              state <= S_DONE;
            end else begin
              cnt   <= md.op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (md.flush) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (ctl_q.is_div) begin
              rem_q <= rem_nxt;
              quo_q <= quo_nxt;
            end
            if (cnt == CW'(1)) begin
              state <= S_DONE;
              if (ctl_q.is_div) begin
                hi_q <= ctl_q.sign_r ? -rem_nxt : rem_nxt;
                lo_q <= ctl_q.sign_q ? -quo_nxt : quo_nxt;
              end else begin
                hi_q <= prod_fix[63:32];
                lo_q <= prod_fix[31:0];
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md.stall_o      = resetn & (((state == S_IDLE) & md.start & ~md.flush) | (state == S_RUN));
  assign md.busy         = (state != S_IDLE);
  assign md.result_valid = (state == S_DONE) & ~md.flush;
  assign md.hi_o         = hi_q;
  assign md.lo_o         = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, flush/reset sequences, random ops vs an arithmetic model.
// Honors MULDIV_EARLY_OUT_EN for the expected divide latency.
module tb_muldiv_ctrl;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;
  localparam int TIMEOUT    = 200;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operand values.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa, sb, p, q, r;
    if (op[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (!op[1]) begin
      p   = sa * sb;
      hi  = p[63:32];
      lo  = p[31:0];
      lat = MUL_CYCLES + 1;
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      hi  = r[31:0];
      lo  = q[31:0];
      lat = DIV_CYCLES + 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (((sa < 0) ? -sa : sa) < ((sb < 0) ? -sb : sb)) lat = 1;
`endif
    end
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
    int lat      = 0;
    bit done     = 1'b0;
    bit stall_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.flush = 1'b0;
    #1 chk({name, " stall_first"}, 64'(bus.stall_o), 64'd1);
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      #1 lat++;
      if (bus.result_valid) done = 1'b1;
      else if (!bus.stall_o) stall_ok = 1'b0;
    end
    chk({name, " latency"}, 64'(lat), 64'(elat));
    chk({name, " stall_held"}, 64'(stall_ok), 64'd1);
    chk({name, " hi"}, 64'(bus.hi_o), 64'(ehi));
    chk({name, " lo"}, 64'(bus.lo_o), 64'(elo));
    chk({name, " stall_done"}, 64'(bus.stall_o), 64'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1 chk({name, " pulse_once"}, 64'(bus.result_valid), 64'd0);
    chk({name, " idle_after"}, 64'(bus.busy), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    logic [1:0]  rop;
    int          elat;

    vecs.push_back('{"divu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          32'd14,         DIV_CYCLES + 1});
    vecs.push_back('{"div_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  DIV_CYCLES + 1});
    vecs.push_back('{"mult_m1_m1",   2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1,          MUL_CYCLES + 1});
    vecs.push_back('{"multu_max",    2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          MUL_CYCLES + 1});
    vecs.push_back('{"divu_by0",     2'b11, 32'h1234,       32'd0,          32'h1234,       32'hFFFF_FFFF,  1});
    vecs.push_back('{"div_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  DIV_CYCLES + 1});
    vecs.push_back('{"div_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  DIV_CYCLES + 1});
    vecs.push_back('{"mult_min_2",   2'b00, 32'h8000_0000,  32'd2,          32'hFFFF_FFFF,  32'd0,          MUL_CYCLES + 1});
`ifdef MULDIV_EARLY_OUT_EN
    vecs.push_back('{"divu_3_10",    2'b11, 32'd3,          32'd10,         32'd3,          32'd0,          1});
    vecs.push_back('{"div_m3_10",    2'b10, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  32'd0,          1});
    vecs.push_back('{"div_0_5",      2'b10, 32'd0,          32'd5,          32'd0,          32'd0,          1});
`else
    vecs.push_back('{"divu_3_10",    2'b11, 32'd3,          32'd10,         32'd3,          32'd0,          DIV_CYCLES + 1});
    vecs.push_back('{"div_m3_10",    2'b10, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  32'd0,          DIV_CYCLES + 1});
    vecs.push_back('{"div_0_5",      2'b10, 32'd0,          32'd5,          32'd0,          32'd0,          DIV_CYCLES + 1});
`endif

    // Reset state, with start raised to confirm stall is masked during reset.
    bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd9; bus.src_b = 32'd2; bus.flush = 1'b0;
    resetn = 1'b0;
    #2;
    chk("rst stall", 64'(bus.stall_o), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst valid", 64'(bus.result_valid), 64'd0);
    chk("rst hi", 64'(bus.hi_o), 64'd0);
    chk("rst lo", 64'(bus.lo_o), 64'd0);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Flush with start in IDLE: never accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.src_a = 32'd5; bus.src_b = 32'd6;
    #1 chk("flush_idle stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1 chk("flush_idle busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0; bus.flush = 1'b0;

    // Flush at RUN cycle 10 of a DIV: no result, HI/LO retained from the previous op.
    run_op("pre_flush", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYCLES + 1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'hFFFF_FF9C; bus.src_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 chk("flush_run busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b0;
    #1 chk("flush_run valid", 64'(bus.result_valid), 64'd0);
    @(posedge clk);
    #1 chk("flush_run idle", 64'(bus.busy), 64'd0);
    chk("flush_run valid2", 64'(bus.result_valid), 64'd0);
    chk("flush_run hi", 64'(bus.hi_o), 64'd2);
    chk("flush_run lo", 64'(bus.lo_o), 64'd14);
    bus.flush = 1'b0;
    run_op("post_flush", 2'b11, 32'd1000, 32'd33, 32'd10, 32'd30, DIV_CYCLES + 1);

    // Flush during DONE suppresses the pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd5;
    repeat (MUL_CYCLES + 1) @(posedge clk);
    #1 chk("flush_done in_done", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1; bus.start = 1'b0;
    #1 chk("flush_done valid", 64'(bus.result_valid), 64'd0);
    @(posedge clk);
    #1 chk("flush_done idle", 64'(bus.busy), 64'd0);
    bus.flush = 1'b0;

    // Random operations against the model.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       ra = 32'($urandom_range(0, 50));
        1:       ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 40));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, ehi, elo, elat);
      run_op("rand", rop, ra, rb, ehi, elo, elat);
    end

    // Reset in the middle of a divide drops the operation at once.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd77; bus.src_b = 32'd5;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    bus.start = 1'b0;
    #1 chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst stall", 64'(bus.stall_o), 64'd0);
    chk("midrst valid", 64'(bus.result_valid), 64'd0);
    chk("midrst hi", 64'(bus.hi_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after_rst", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_CYCLES + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
